lsu_ram_master: RTL and testbench
=================================

Name: lsu_ram_master

Overview:
- Load/store initiator driving the word-wide data RAM: async read, sync write, separate read/write enables, no byte enables.
- Accepts byte/halfword/word requests from the core pipeline with byte addresses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Sits between the core's MEM stage and the data RAM, and owns every RAM control signal.

Parameters:
- ANCHO, 32, RAM word width; only 32 is supported, elaborate-time error otherwise.
- LARGO, 1024, RAM depth in words.
- AW, 32, width of the core byte address.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as an error
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  AW  byte address
- req_wdata  in  ANCHO  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  ANCHO  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or size 11
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_addr  out  $clog2(LARGO)  word address = req_addr[$clog2(LARGO)+1:2]
- ram_din  out  ANCHO  RAM write data
- ram_dout  in  ANCHO  RAM read data, valid in the same cycle as ram_re

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; all latched request fields 0.
- ram_we and ram_re are decoded from state and ANDed with !rst, so no RAM write is issued during a reset cycle.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we, size, unsigned, addr, wdata, and evaluate the error conditions.
  - Error -> RESP with err=1; no RAM access.
  - Load or sub-word store -> RD.
  - Word store -> WR.
- Error conditions:
  - half at addr[0]=1;
  - word at addr[1:0]!=0;
  - size 11;
  - any addr bit above $clog2(LARGO)+1 set.
- RD:
  - ram_re=1; ram_addr from the latched addr; sample ram_dout at the clock edge.
  - Load: select lane by addr[1:0], extend per size/unsigned into resp_rdata -> RESP.
  - Sub-word store: latch the old word -> WR.
- WR:
  - ram_we=1.
  - Word store: ram_din = wdata.
  - Byte store: old word with lane addr[1:0] replaced by wdata[7:0].
  - Half store: old word with lane addr[1] replaced by wdata[15:0].
  - Next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; the core cannot stall the response.
  - Next state IDLE; req_ready stays 0 during this cycle.
- Latency from acceptance edge to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Lane order is little-endian: byte 0 = bits 7:0.
- Outside RD/WR, ram_addr, ram_din and the enables are 0.
- Reset in any state: next edge goes to IDLE; the in-flight access is dropped with no response.
- A req_valid held through RESP is accepted on the following IDLE cycle; there is no back-to-back acceptance.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - misaligned half/word requests complete with resp_err=1 and no RAM access.
- Not defined:
  - misaligned requests are silently aligned: addr[0] is cleared for half, addr[1:0] for word, then processed normally;
  - size 11 and out-of-range requests are still errors.

Decomposition:
- Package lsu_pkg:
  - size_t enum (SZ_B, SZ_H, SZ_W, SZ_RSV);
  - state_t enum (IDLE, RD, WR, RESP);
  - constant WORD_BYTES=4.
- Sub-module lsu_align, purely combinational:
  - load extract/extend (word, size, unsigned, offset -> data);
  - store merge (old word, wdata, size, offset -> new word).
- The FSM stays in lsu_ram_master.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF -> ram_we pulse at word 4, ram_din 0xDEADBEEF. Load word 0x10 -> resp_rdata 0xDEADBEEF, 2 cycles after acceptance.
- Byte RMW: word 4 = 0x11223344; store byte 0xAA at 0x12 -> RD, then WR with ram_din 0x11AA3344; resp 3 cycles after acceptance.
- Extension: word 4 = 0x8000FF7F.
  - Load byte signed 0x11 -> 0xFFFFFFFF.
  - Load byte unsigned 0x11 -> 0x000000FF.
  - Load half signed 0x12 -> 0xFFFF8000.
- Misaligned word load at 0x13:
  - with LSU_MISALIGN_TRAP_EN: resp_err=1 after 1 cycle, ram_re never asserted;
  - without it: reads word 4, err=0.
- Out-of-range address 0x00001000 (LARGO=1024), and size 11 -> resp_err=1, no RAM enable.
- Assert rst while in WR for a byte store -> ram_we=0 that cycle, word unchanged, state IDLE, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-size and FSM state types plus word geometry for the LSU RAM master
package lsu_pkg;
   typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_RSV = 2'b11} size_t;
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] rword_i,
   input  logic [31:0] old_i,
   input  logic [31:0] wdata_i,
   input  size_t       size_i,
   input  logic        uns_i,
   input  logic [1:0]  off_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   // pick the addressed lane and extend it; overwrite only the addressed lane of the old word
   always_comb begin
      lane_b  = rword_i[{off_i, 3'b000} +: 8];
      lane_h  = off_i[1] ? rword_i[31:16] : rword_i[15:0];
      load_o  = size_i == SZ_B ? {{24{~uns_i & lane_b[7]}}, lane_b}
              : size_i == SZ_H ? {{16{~uns_i & lane_h[15]}}, lane_h} : rword_i;
      merge_o = old_i;
      if (size_i == SZ_B) merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      else if (size_i == SZ_H) merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      else merge_o = wdata_i;
   end
endmodule

// File: rtl/lsu_ram_master.sv
// lsu_ram_master: core load/store requests to a word-wide RAM with RMW sub-word stores (option: LSU_MISALIGN_TRAP_EN)
module lsu_ram_master
   import lsu_pkg::*;
#(
   parameter int ANCHO = 32,
   parameter int LARGO = 1024,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [AW-1:0]            req_addr,
   input  logic [ANCHO-1:0]         req_wdata,
   output logic                     resp_valid,
   output logic [ANCHO-1:0]         resp_rdata,
   output logic                     resp_err,
   output logic                     ram_we,
   output logic                     ram_re,
   output logic [$clog2(LARGO)-1:0] ram_addr,
   output logic [ANCHO-1:0]         ram_din,
   input  logic [ANCHO-1:0]         ram_dout
);
   localparam int OB = $clog2(WORD_BYTES);
   localparam int LW = $clog2(LARGO);

   if (ANCHO != 32) begin : g_bad_ancho
      $error("lsu_ram_master: only ANCHO=32 is supported");
   end

   state_t           state_q, state_d;
   logic             we_q, uns_q, err_q;
   size_t            size_q, req_sz;
   logic [LW+OB-1:0] addr_q, acc_addr;
   logic [ANCHO-1:0] wdata_q, old_q, rdata_q, load_w, merge_w;
   logic             req_err;

   lsu_align u_align (
      .rword_i (ram_dout),
      .old_i   (old_q),
      .wdata_i (wdata_q),
      .size_i  (size_q),
      .uns_i   (uns_q),
      .off_i   (addr_q[1:0]),
      .load_o  (load_w),
      .merge_o (merge_w)
   );

   // classify the incoming request and form the address to latch
   always_comb begin
      req_sz = size_t'(req_size);
`ifdef LSU_MISALIGN_TRAP_EN
      req_err  = (req_addr >> (LW + OB)) != '0 || req_sz == SZ_RSV
              || (req_sz == SZ_H && req_addr[0]) || (req_sz == SZ_W && req_addr[1:0] != 2'b00);
      acc_addr = req_addr[LW+OB-1:0];
`else
      req_err  = (req_addr >> (LW + OB)) != '0 || req_sz == SZ_RSV;
      acc_addr = {req_addr[LW+OB-1:OB], req_addr[1] & (req_sz != SZ_W), req_addr[0] & (req_sz == SZ_B)};
`endif
   end

   // next state and all state-decoded outputs; RAM enables are blocked during reset
   always_comb begin
      req_ready  = state_q == IDLE;
      resp_valid = state_q == RESP;
      ram_re     = state_q == RD && !rst;
      ram_we     = state_q == WR && !rst;
      ram_addr   = (state_q == RD || state_q == WR) ? addr_q[LW+OB-1:OB] : '0;
      ram_din    = state_q == WR ? merge_w : '0;
      resp_rdata = resp_valid ? rdata_q : '0;
      resp_err   = resp_valid && err_q;
      state_d    = state_q == IDLE ? (!req_valid ? IDLE : req_err ? RESP : (!req_we || req_sz != SZ_W) ? RD : WR)
                 : state_q == RD   ? (we_q ? WR : RESP)
                 : state_q == WR   ? RESP : IDLE;
   end

   // state register, request capture on acceptance, and RAM word capture in RD
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         old_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            size_q  <= req_sz;
            uns_q   <= req_unsigned;
            addr_q  <= acc_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
         end
         if (state_q == RD && we_q) old_q <= ram_dout;
         if (state_q == RD && !we_q) rdata_q <= load_w;
      end
   end
endmodule

// File: tb/tb_lsu_ram_master.sv
// tb_lsu_ram_master: table-driven directed checks of lsu_ram_master against a behavioural RAM
module tb_lsu_ram_master;
   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, resp_rdata, ram_din, ram_dout;
   logic        resp_valid, resp_err, ram_we, ram_re;
   logic [9:0]  ram_addr;
   logic [31:0] mem [0:1023];
   logic        pre_we;
   logic [9:0]  pre_a;
   logic [31:0] pre_d;
   int          n_run = 0, n_fail = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr, wdata;
      logic        pre;
      logic [31:0] pre_val;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic        re, wr;
      logic [31:0] din;
      logic [9:0]  wa;
   } vec_t;
   vec_t vq[$];

   lsu_ram_master #(.ANCHO(32), .LARGO(1024), .AW(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   assign ram_dout = mem[ram_addr];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else if (pre_we) mem[pre_a] <= pre_d;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_a = a; pre_d = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic add(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic pre, input logic [31:0] pv,
                      input logic [31:0] rd, input logic er, input int lat, input logic re, input logic wr,
                      input logic [31:0] din, input logic [9:0] wa);
      vec_t v;
      v.name = nm; v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.pre = pre; v.pre_val = pv;
      v.rdata = rd; v.err = er; v.lat = lat; v.re = re; v.wr = wr; v.din = din; v.wa = wa;
      vq.push_back(v);
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er,
                        output logic sre, output logic swe, output logic [31:0] din, output logic [9:0] wa,
                        output logic rdy_resp);
      @(negedge clk);
      for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1; sre = 1'b0; swe = 1'b0; din = '0; wa = '0; rd = '0; er = 1'b0; rdy_resp = 1'b1;
      while (lat < 8) begin
         if (ram_re) begin sre = 1'b1; wa = ram_addr; end
         if (ram_we) begin swe = 1'b1; din = ram_din; wa = ram_addr; end
         if (resp_valid) begin rd = resp_rdata; er = resp_err; rdy_resp = req_ready; break; end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] rd, din;
      logic        er, sre, swe, rdy, seen;
      logic [9:0]  wa;
      logic [3:0]  pat_v, pat_r;

      add("st_w",         1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0,        32'h0,        0, 2, 0, 1, 32'hDEADBEEF, 10'd4);
      add("ld_w",         0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'h0,        10'd4);
      add("st_b_rmw",     1, 2'b00, 0, 32'h12, 32'hAA,       1, 32'h11223344, 32'h0,        0, 3, 1, 1, 32'h11AA3344, 10'd4);
      add("ld_after_rmw", 0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h0,        32'h11AA3344, 0, 2, 1, 0, 32'h0,        10'd4);
      add("ld_b_s",       0, 2'b00, 0, 32'h11, 32'h0,        1, 32'h8000FF7F, 32'hFFFFFFFF, 0, 2, 1, 0, 32'h0,        10'd4);
      add("ld_b_u",       0, 2'b00, 1, 32'h11, 32'h0,        0, 32'h0,        32'h000000FF, 0, 2, 1, 0, 32'h0,        10'd4);
      add("ld_h_s",       0, 2'b01, 0, 32'h12, 32'h0,        0, 32'h0,        32'hFFFF8000, 0, 2, 1, 0, 32'h0,        10'd4);
      add("ld_h_u",       0, 2'b01, 1, 32'h12, 32'h0,        0, 32'h0,        32'h00008000, 0, 2, 1, 0, 32'h0,        10'd4);
      add("ld_b_s_lane0", 0, 2'b00, 0, 32'h10, 32'h0,        0, 32'h0,        32'h0000007F, 0, 2, 1, 0, 32'h0,        10'd4);
      add("st_h_rmw",     1, 2'b01, 0, 32'h12, 32'h1234BEEF, 0, 32'h0,        32'h0,        0, 3, 1, 1, 32'hBEEFFF7F, 10'd4);
      add("ld_after_sth", 0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h0,        32'hBEEFFF7F, 0, 2, 1, 0, 32'h0,        10'd4);
`ifdef LSU_MISALIGN_TRAP_EN
      add("mis_ld_w",     0, 2'b10, 0, 32'h13, 32'h0,        0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        10'd0);
      add("mis_ld_h",     0, 2'b01, 0, 32'h13, 32'h0,        0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        10'd0);
`else
      add("mis_ld_w",     0, 2'b10, 0, 32'h13, 32'h0,        0, 32'h0,        32'hBEEFFF7F, 0, 2, 1, 0, 32'h0,        10'd4);
      add("mis_ld_h",     0, 2'b01, 0, 32'h13, 32'h0,        0, 32'h0,        32'hFFFFBEEF, 0, 2, 1, 0, 32'h0,        10'd4);
`endif
      add("oor_ld",       0, 2'b10, 0, 32'h1000, 32'h0,      0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        10'd0);
      add("rsv_ld",       0, 2'b11, 0, 32'h10, 32'h0,        0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        10'd0);
      add("oor_st_b",     1, 2'b00, 0, 32'h80000010, 32'hFF, 0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        10'd0);
      add("st_b_lane3",   1, 2'b00, 0, 32'h13, 32'h55,       0, 32'h0,        32'h0,        0, 3, 1, 1, 32'h55EFFF7F, 10'd4);
      add("ld_lane3_w",   0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h0,        32'h55EFFF7F, 0, 2, 1, 0, 32'h0,        10'd4);
`ifdef LSU_MISALIGN_TRAP_EN
      add("mis_st_w",     1, 2'b10, 0, 32'h16, 32'hCAFEF00D, 0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        10'd0);
      add("ld_w5",        0, 2'b10, 0, 32'h14, 32'h0,        0, 32'h0,        32'h0,        0, 2, 1, 0, 32'h0,        10'd5);
`else
      add("mis_st_w",     1, 2'b10, 0, 32'h16, 32'hCAFEF00D, 0, 32'h0,        32'h0,        0, 2, 0, 1, 32'hCAFEF00D, 10'd5);
      add("ld_w5",        0, 2'b10, 0, 32'h14, 32'h0,        0, 32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 32'h0,        10'd5);
`endif
      add("ld_top_w",     0, 2'b10, 0, 32'hFFC, 32'h0,       0, 32'h0,        32'h0BADF00D, 0, 2, 1, 0, 32'h0,        10'd1023);
      add("ld_top_b_u",   0, 2'b00, 1, 32'hFFF, 32'h0,       0, 32'h0,        32'h0000000B, 0, 2, 1, 0, 32'h0,        10'd1023);

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_err", resp_err, 0);
      check("rst_ram_re", ram_re, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      rst = 1'b0;
      preload(10'd5, 32'h0);
      preload(10'd1023, 32'h0BADF00D);

      foreach (vq[k]) begin
         if (vq[k].pre) preload(10'd4, vq[k].pre_val);
         issue(vq[k].we, vq[k].sz, vq[k].uns, vq[k].addr, vq[k].wdata, lat, rd, er, sre, swe, din, wa, rdy);
         check({vq[k].name, "_lat"}, lat, vq[k].lat);
         check({vq[k].name, "_rdata"}, rd, vq[k].rdata);
         check({vq[k].name, "_err"}, er, {31'b0, vq[k].err});
         check({vq[k].name, "_re"}, sre, {31'b0, vq[k].re});
         check({vq[k].name, "_we"}, swe, {31'b0, vq[k].wr});
         check({vq[k].name, "_ready_in_resp"}, rdy, 0);
         if (vq[k].wr) check({vq[k].name, "_din"}, din, vq[k].din);
         if (vq[k].re || vq[k].wr) check({vq[k].name, "_ram_addr"}, wa, vq[k].wa);
         @(posedge clk); #1;
         check({vq[k].name, "_pulse_end"}, resp_valid, 0);
      end

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 32'h10;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         pat_v[3-i] = resp_valid;
         pat_r[3-i] = req_ready;
         if (i < 3) begin @(posedge clk); #1; end
      end
      req_valid = 1'b0;
      check("held_valid_pattern", pat_v, 4'b1010);
      check("held_ready_pattern", pat_r, 4'b0101);
      repeat (2) @(posedge clk);

      preload(10'd4, 32'h11223344);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h12; req_wdata = 32'hAA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_wr_we_before", ram_we, 1);
      rst = 1'b1;
      #1;
      check("rst_wr_we_gated", ram_we, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_wr_idle", req_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid || ram_we) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("rst_wr_no_resp", seen, 0);
      check("rst_wr_word_kept", mem[4], 32'h11223344);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
